// File: rtl/regfile_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback_arbiter
// Brief    : Merges ALU results (priority) and queued load returns onto the
//            single register-file write port; tracks pending loads per register.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_writeback_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              clk_reset,
    input  logic              alu_wr_valid,
    input  logic [ADDR_W-1:0] alu_wr_addr,
    input  logic [DATA_W-1:0] alu_wr_data,
    input  logic              ld_issue_valid,
    input  logic [ADDR_W-1:0] ld_issue_addr,
    input  logic              ld_rsp_valid,
    output logic              ld_rsp_ready,
    input  logic [ADDR_W-1:0] ld_rsp_addr,
    input  logic [DATA_W-1:0] ld_rsp_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              lq_full,
    output logic              lq_empty
);

    localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int NREG  = 1 << ADDR_W;
    localparam logic [PTR_W:0]   c_FULL_CNT = (PTR_W + 1)'(LQ_DEPTH);
    localparam logic [PTR_W:0]   c_CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE  = PTR_W'(1);

    logic [ADDR_W-1:0] r_lq_addr [LQ_DEPTH];
    logic [DATA_W-1:0] r_lq_data [LQ_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_full;
    logic              r_empty;
    logic [NREG-1:0]   r_busy;
    logic              r_wb_we;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;

    logic              w_push;
    logic              w_pop;
    logic              w_alu_sel;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic [PTR_W:0]    w_count_nxt;
    logic [NREG-1:0]   w_busy_nxt;

    // An ALU write to r0 is treated as an idle slot so the queue may drain.
    assign w_alu_sel   = alu_wr_valid && (alu_wr_addr != '0);
    assign w_push      = ld_rsp_valid && !r_full;
    assign w_pop       = !w_alu_sel && !r_empty;
    assign w_head_addr = r_lq_addr[r_rd_ptr];
    assign w_head_data = r_lq_data[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    // Entry storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_lq_addr[r_wr_ptr] <= ld_rsp_addr;
            r_lq_data[r_wr_ptr] <= ld_rsp_data;
        end
    end

    always_ff @(posedge clk or negedge clk_reset) begin
        if (!clk_reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_FULL_CNT);
            r_empty <= (w_count_nxt == '0);
        end
    end

    // A new issue on the same edge as a pop to the same register keeps it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) begin
            w_busy_nxt[w_head_addr] = 1'b0;
        end
        if (ld_issue_valid) begin
            w_busy_nxt[ld_issue_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge clk_reset) begin
        if (!clk_reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    always_ff @(posedge clk or negedge clk_reset) begin
        if (!clk_reset) begin
            r_wb_we   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else if (w_alu_sel) begin
            r_wb_we   <= 1'b1;
            r_wb_addr <= alu_wr_addr;
            r_wb_data <= alu_wr_data;
        end else if (w_pop) begin
            r_wb_we   <= (w_head_addr != '0);
            r_wb_addr <= w_head_addr;
            r_wb_data <= w_head_data;
        end else begin
            r_wb_we   <= 1'b0;
        end
    end

    assign ld_rsp_ready = !r_full;
    assign lq_full      = r_full;
    assign lq_empty     = r_empty;
    assign rd_busy1     = r_busy[rd_addr1];
    assign rd_busy2     = r_busy[rd_addr2];
    assign wb_we        = r_wb_we;
    assign wb_addr      = r_wb_addr;
    assign wb_data      = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_writeback_arbiter
// Brief    : Scoreboard bench for regfile_writeback_arbiter with directed and
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback_arbiter;

    localparam int LQ = 4;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        clk_reset = 1'b0;
    logic        alu_wr_valid = 1'b0;
    logic [4:0]  alu_wr_addr = '0;
    logic [31:0] alu_wr_data = '0;
    logic        ld_issue_valid = 1'b0;
    logic [4:0]  ld_issue_addr = '0;
    logic        ld_rsp_valid = 1'b0;
    logic        ld_rsp_ready;
    logic [4:0]  ld_rsp_addr = '0;
    logic [31:0] ld_rsp_data = '0;
    logic [4:0]  rd_addr1 = '0;
    logic [4:0]  rd_addr2 = '0;
    logic        rd_busy1, rd_busy2;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lq_full, lq_empty;

    regfile_writeback_arbiter #(.DATA_W(32), .ADDR_W(5), .LQ_DEPTH(LQ)) dut (
        .clk(clk), .clk_reset(clk_reset),
        .alu_wr_valid(alu_wr_valid), .alu_wr_addr(alu_wr_addr), .alu_wr_data(alu_wr_data),
        .ld_issue_valid(ld_issue_valid), .ld_issue_addr(ld_issue_addr),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_ready(ld_rsp_ready),
        .ld_rsp_addr(ld_rsp_addr), .ld_rsp_data(ld_rsp_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .lq_full(lq_full), .lq_empty(lq_empty)
    );

    always #5 clk = ~clk;

    // Reference model state
    wr_t         mq[$];
    wr_t         exp_q[$];
    bit          busy_m[32];
    bit          rsp_acc;
    wr_t         m_head;
    wr_t         m_new;
    // Stimulus state: issued loads whose response has not been accepted yet
    logic [4:0]  iss_q[$];
    logic [31:0] rsp_data_h;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk or negedge clk_reset) begin
        if (!clk_reset) begin
            mq.delete();
            foreach (busy_m[i]) busy_m[i] = 1'b0;
            rsp_acc = 1'b0;
        end else begin
            rsp_acc = ld_rsp_valid && (mq.size() < LQ);
            if (alu_wr_valid && alu_wr_addr != 5'd0) begin
                m_new.a = alu_wr_addr;
                m_new.d = alu_wr_data;
                exp_q.push_back(m_new);
            end else if (mq.size() > 0) begin
                m_head = mq.pop_front();
                if (m_head.a != 5'd0) exp_q.push_back(m_head);
                busy_m[m_head.a] = 1'b0;
            end
            if (ld_issue_valid && ld_issue_addr != 5'd0) busy_m[ld_issue_addr] = 1'b1;
            if (rsp_acc) begin
                m_new.a = ld_rsp_addr;
                m_new.d = ld_rsp_data;
                mq.push_back(m_new);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (!clk_reset) begin
            chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
            chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
            chk("rst_wb_data", wb_data, 32'd0);
            chk("rst_lq_empty", {31'd0, lq_empty}, 32'd1);
            chk("rst_lq_full", {31'd0, lq_full}, 32'd0);
            chk("rst_ready", {31'd0, ld_rsp_ready}, 32'd1);
            chk("rst_busy1", {31'd0, rd_busy1}, 32'd0);
            chk("rst_busy2", {31'd0, rd_busy2}, 32'd0);
        end else begin
            n_checks++;
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                if (wb_we !== 1'b1 || wb_addr !== e.a || wb_data !== e.d) begin
                    n_fail++;
                    $display("FAIL wb_write: got we=%b addr=%0d data=%h, expected we=1 addr=%0d data=%h at %0t",
                             wb_we, wb_addr, wb_data, e.a, e.d, $time);
                end
            end else if (wb_we !== 1'b0) begin
                n_fail++;
                $display("FAIL wb_idle: got we=%b addr=%0d, expected we=0 at %0t", wb_we, wb_addr, $time);
            end
            chk("rd_busy1", {31'd0, rd_busy1}, {31'd0, busy_m[rd_addr1]});
            chk("rd_busy2", {31'd0, rd_busy2}, {31'd0, busy_m[rd_addr2]});
            chk("lq_full", {31'd0, lq_full}, {31'd0, mq.size() == LQ});
            chk("lq_empty", {31'd0, lq_empty}, {31'd0, mq.size() == 0});
            chk("ld_rsp_ready", {31'd0, ld_rsp_ready}, {31'd0, mq.size() != LQ});
        end
    end

    function automatic bit in_iss(input logic [4:0] a);
        foreach (iss_q[i]) if (iss_q[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [4:0] pick_free(input logic [4:0] avoid);
        logic [4:0] a;
        for (int k = 0; k < 64; k++) begin
            a = 5'($urandom_range(1, 31));
            if (!busy_m[a] && a != avoid && !in_iss(a)) return a;
        end
        return 5'd0;
    endfunction

    task automatic step(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                        input bit iv, input logic [4:0] ia, input bit ren,
                        input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        if (rsp_acc && ld_rsp_valid && iss_q.size() > 0) begin
            void'(iss_q.pop_front());
            rsp_data_h = $urandom;
        end
        alu_wr_valid = av;
        alu_wr_addr  = aa;
        alu_wr_data  = ad;
        ld_rsp_valid = ren && (iss_q.size() > 0);
        ld_rsp_addr  = (iss_q.size() > 0) ? iss_q[0] : 5'd0;
        ld_rsp_data  = rsp_data_h;
        ld_issue_valid = iv;
        ld_issue_addr  = ia;
        if (iv) iss_q.push_back(ia);
        rd_addr1 = r1;
        rd_addr2 = r2;
    endtask

    task automatic idle(input int n, input logic [4:0] r1, input logic [4:0] r2);
        for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, 0, 5'd0, 1, r1, r2);
    endtask

    initial begin
        bit          av, iv;
        logic [4:0]  aa, ia;
        rsp_data_h = $urandom;

        // Reset held while all inputs toggle
        for (int i = 0; i < 4; i++)
            step(1, 5'($urandom), $urandom, 1, 5'($urandom), 1, 5'($urandom), 5'($urandom));
        iss_q.delete();
        @(negedge clk);
        #2 clk_reset = 1'b1;
        idle(3, 5'd3, 5'd7);

        // ALU to r5, then ALU to r0
        step(1, 5'd5, 32'h0000_1234, 0, 5'd0, 0, 5'd5, 5'd0);
        step(1, 5'd0, 32'h0000_FFFF, 0, 5'd0, 0, 5'd5, 5'd0);
        idle(2, 5'd5, 5'd0);

        // Single load r8
        step(0, 5'd0, 32'd0, 1, 5'd8, 0, 5'd8, 5'd9);
        rsp_data_h = 32'hDEAD_BEEF;
        step(0, 5'd0, 32'd0, 0, 5'd0, 1, 5'd8, 5'd9);
        idle(3, 5'd8, 5'd9);

        // Queue fill under ALU pressure
        for (int i = 0; i < 5; i++) step(0, 5'd0, 32'd0, 1, 5'(9 + i), 0, 5'(9 + i), 5'd13);
        for (int i = 0; i < 6; i++) step(1, 5'(1 + i), $urandom, 0, 5'd0, 1, 5'd9, 5'd13);
        idle(8, 5'd11, 5'd13);

        // Pop and re-issue of r8 on the same edge; issue to r0
        step(0, 5'd0, 32'd0, 1, 5'd8, 0, 5'd8, 5'd0);
        step(0, 5'd0, 32'd0, 0, 5'd0, 1, 5'd8, 5'd0);
        step(0, 5'd0, 32'd0, 1, 5'd8, 0, 5'd8, 5'd0);
        step(0, 5'd0, 32'd0, 1, 5'd0, 0, 5'd0, 5'd8);
        step(0, 5'd0, 32'd0, 0, 5'd0, 0, 5'd0, 5'd8);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            iv = ($urandom_range(0, 3) == 0) && (iss_q.size() < 6);
            ia = ($urandom_range(0, 9) == 0) ? 5'd0 : pick_free(5'd0);
            av = ($urandom_range(0, 2) != 0);
            aa = ($urandom_range(0, 9) == 0) ? 5'd0 : pick_free(iv ? ia : 5'd0);
            step(av, aa, $urandom, iv, ia, 1'($urandom_range(0, 1)),
                 5'($urandom), iss_q.size() > 0 ? iss_q[0] : 5'($urandom));
        end
        idle(20, 5'd1, 5'd2);

        // Reset with loads queued behind continuous ALU traffic
        for (int i = 0; i < 3; i++) step(0, 5'd0, 32'd0, 1, 5'(20 + i), 0, 5'd20, 5'd21);
        for (int i = 0; i < 4; i++) step(1, 5'(1 + i), $urandom, 0, 5'd0, 1, 5'd20, 5'd22);
        #2 clk_reset = 1'b0;
        step(1, 5'd5, $urandom, 0, 5'd0, 0, 5'd20, 5'd21);
        iss_q.delete();
        step(0, 5'd0, 32'd0, 0, 5'd0, 0, 5'd20, 5'd21);
        @(negedge clk);
        #2 clk_reset = 1'b1;
        idle(10, 5'd20, 5'd22);

        chk("exp_q_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
